// File: rtl/imem_loader.sv
// Purpose : boot loader that writes a framed byte stream into instruction memory and releases the CPU on a verified frame.
// Latency : one im_we pulse on the cycle after the 4th byte of each word is accepted; done/err one cycle after the CHK byte.
// Backpressure: rx_ready drops for the single WRITE cycle of every word and outside frame reception; unaccepted bytes are never consumed.
//
// Ports
//   CLK       system clock, rising edge
//   RST       asynchronous active-low reset
//   start     pulse that begins a frame; acted on only while idle, done or in error
//   rx_data   stream byte
//   rx_valid  rx_data is valid
//   rx_ready  loader can take a byte this cycle (transfer = rx_valid & rx_ready)
//   im_we     instruction-memory write strobe, one cycle per word
//   im_addr   word address of the write, held between writes
//   im_wdata  word written, held between writes
//   cpu_hold  keep the CPU core in reset (released only after a good frame)
//   busy      a frame is being received
//   done      frame loaded and checksum matched (level until next start/reset)
//   err       frame rejected (level until next start/reset)
//
// Frame format: CNT_HI, CNT_LO (word count N, big-endian), 4*N payload bytes
// (each word MSB first), then one checksum byte equal to the XOR of the payload.

module imem_loader #(
    parameter int ADDR_W = 10
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              im_we,
    output logic [ADDR_W-1:0] im_addr,
    output logic [31:0]       im_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              done,
    output logic              err
);

    // Largest word count that fits the memory.
    localparam int unsigned CAPACITY = 32'd1 << ADDR_W;

    typedef enum logic [2:0] {
        IDLE,
        HDR_HI,
        HDR_LO,
        PAYLOAD,
        WRITE,
        CHECK,
        DONE,
        ERR
    } loaderState_t;

    loaderState_t state;
    loaderState_t stateNext;

    logic [7:0]      lenHi;      // first header byte, waiting for its low half
    logic [15:0]     frameLen;   // N, number of words in the frame
    logic [1:0]      byteCnt;    // position of the next payload byte inside its word
    logic [ADDR_W:0] wordIdx;    // one bit wider than the address so N = capacity does not wrap
    logic [7:0]      checksum;   // running XOR of accepted payload bytes
    logic [23:0]     wordAcc;    // the three most recent payload bytes, oldest in the top byte

    logic            accept;
    logic            startTake;
    logic [15:0]     lenFull;
    logic            lenBad;
    logic            lastWord;

    assign accept  = rx_valid & rx_ready;
    assign lenFull = {lenHi, rx_data};

    // Zero-length frames and frames larger than the memory are rejected
    // before a single write is issued.
    assign lenBad = (lenFull == 16'd0) || (32'(lenFull) > CAPACITY);

    // The word being written in WRITE is the final one of the frame.
    assign lastWord = ((32'(wordIdx) + 32'd1) == 32'(frameLen));

    //------------------------------------------------------------------
    // State register
    //------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    //------------------------------------------------------------------
    // Next state and state-decoded outputs
    //------------------------------------------------------------------
    always_comb begin
        stateNext = state;
        rx_ready  = 1'b0;
        im_we     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        cpu_hold  = 1'b1;
        startTake = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    startTake = 1'b1;
                    stateNext = HDR_HI;
                end
            end

            HDR_HI: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) begin
                    stateNext = HDR_LO;
                end
            end

            HDR_LO: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) begin
                    stateNext = lenBad ? ERR : PAYLOAD;
                end
            end

            PAYLOAD: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid && (byteCnt == 2'd3)) begin
                    stateNext = WRITE;
                end
            end

            WRITE: begin
                // rx_ready stays low here: this bubble is what limits the
                // stream to four bytes every five cycles.
                busy      = 1'b1;
                im_we     = 1'b1;
                stateNext = lastWord ? CHECK : PAYLOAD;
            end

            CHECK: begin
                rx_ready = 1'b1;
                busy     = 1'b1;
                if (rx_valid) begin
                    stateNext = (rx_data == checksum) ? DONE : ERR;
                end
            end

            DONE: begin
                done     = 1'b1;
                cpu_hold = 1'b0;
                if (start) begin
                    startTake = 1'b1;
                    stateNext = HDR_HI;
                end
            end

            ERR: begin
                err = 1'b1;
                if (start) begin
                    startTake = 1'b1;
                    stateNext = HDR_HI;
                end
            end

            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    //------------------------------------------------------------------
    // Datapath: header capture, word assembly, checksum, write port
    //------------------------------------------------------------------
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            lenHi    <= 8'd0;
            frameLen <= 16'd0;
            byteCnt  <= 2'd0;
            wordIdx  <= '0;
            checksum <= 8'd0;
            wordAcc  <= 24'd0;
            im_addr  <= '0;
            im_wdata <= 32'd0;
        end else if (startTake) begin
            byteCnt  <= 2'd0;
            wordIdx  <= '0;
            checksum <= 8'd0;
        end else begin
            case (state)
                HDR_HI: begin
                    if (accept) begin
                        lenHi <= rx_data;
                    end
                end

                HDR_LO: begin
                    if (accept) begin
                        frameLen <= lenFull;
                    end
                end

                PAYLOAD: begin
                    if (accept) begin
                        wordAcc  <= {wordAcc[15:0], rx_data};
                        checksum <= checksum ^ rx_data;
                        byteCnt  <= byteCnt + 2'd1;
                        // Load the write port as the word completes so it is
                        // already valid during the WRITE cycle and then holds.
                        if (byteCnt == 2'd3) begin
                            im_wdata <= {wordAcc, rx_data};
                            im_addr  <= wordIdx[ADDR_W-1:0];
                        end
                    end
                end

                WRITE: begin
                    wordIdx <= wordIdx + 1'b1;
                end

                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

    localparam int ADDR_W = 10;
    localparam int CAP    = 1 << ADDR_W;

    logic              CLK = 1'b0;
    logic              RST;
    logic              start;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              im_we;
    logic [ADDR_W-1:0] im_addr;
    logic [31:0]       im_wdata;
    logic              cpu_hold;
    logic              busy;
    logic              done;
    logic              err;

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .im_we    (im_we),
        .im_addr  (im_addr),
        .im_wdata (im_wdata),
        .cpu_hold (cpu_hold),
        .busy     (busy),
        .done     (done),
        .err      (err)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int fails  = 0;

    typedef struct {
        logic [15:0] n;          // word count placed in the header
        bit          specFrame;  // use the fixed reference frame instead of random payload
        bit          flipChk;    // corrupt the checksum byte
        bit          randValid;  // random rx_valid gaps and stray start pulses
        bit          expDone;
        bit          expErr;
        int          expWrites;
    } vec_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [31:0]       data;
    } wr_t;

    vec_t        vecs [9];
    wr_t         expQ [$];
    wr_t         monE;
    wr_t         lastW;
    logic [7:0]  frameQ [$];
    int          writesSeen;
    int          frameCycles;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    // Every write must match the next expected (address, word) pair, and the
    // loader must not be offering to take a byte while writing.
    always @(negedge CLK) begin
        if (RST === 1'b1 && im_we === 1'b1) begin
            writesSeen++;
            check("rx_ready during write", 32'(rx_ready), 32'd0);
            if (expQ.size() == 0) begin
                checks++;
                fails++;
                $display("FAIL unexpected write: got addr 0x%0h data 0x%0h, required none", im_addr, im_wdata);
            end else begin
                monE = expQ.pop_front();
                check("write addr", 32'(im_addr), 32'(monE.addr));
                check("write data", im_wdata, monE.data);
            end
        end
    end

    // Reference model: interpret a frame's bytes and list the writes the
    // memory should see, in order.
    task automatic modelFrame();
        int n;
        logic [31:0] w;
        expQ.delete();
        n = int'({frameQ[0], frameQ[1]});
        if (n == 0 || n > CAP) return;
        for (int i = 0; i < n; i++) begin
            w = {frameQ[2+4*i], frameQ[3+4*i], frameQ[4+4*i], frameQ[5+4*i]};
            expQ.push_back('{addr: ADDR_W'(i), data: w});
        end
    endtask

    task automatic sendByte(input logic [7:0] b, input bit rv, output bit ok);
        bit taken;
        ok = 1'b0;
        rx_data = b;
        for (int c = 0; c < 200; c++) begin
            rx_valid = (rv && $urandom_range(0, 2) == 0) ? 1'b0 : 1'b1;
            if (rv) start = ($urandom_range(0, 5) == 0);
            taken = rx_valid && rx_ready;
            @(posedge CLK);
            #1;
            start = 1'b0;
            frameCycles++;
            if (taken) begin
                ok = 1'b1;
                break;
            end
        end
        rx_valid = 1'b0;
    endtask

    task automatic pulseStart();
        start = 1'b1;
        @(posedge CLK);
        #1;
        start = 1'b0;
    endtask

    task automatic buildFrame(input vec_t v);
        logic [7:0] chk;
        logic [7:0] b;
        frameQ.delete();
        if (v.specFrame) begin
            frameQ = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05,
                       8'h00, 8'h00, 8'h00, 8'h00, 8'h2D};
            if (v.flipChk) frameQ[10] = 8'h2C;
            expQ.delete();
            expQ.push_back('{addr: ADDR_W'(0), data: 32'h2008_0005});
            expQ.push_back('{addr: ADDR_W'(1), data: 32'h0000_0000});
        end else begin
            frameQ.push_back(v.n[15:8]);
            frameQ.push_back(v.n[7:0]);
            if (v.n != 16'd0 && int'(v.n) <= CAP) begin
                chk = 8'h00;
                for (int i = 0; i < 4 * int'(v.n); i++) begin
                    b = 8'($urandom);
                    frameQ.push_back(b);
                    chk ^= b;
                end
                if (v.flipChk) chk ^= 8'h01;
                frameQ.push_back(chk);
            end
            modelFrame();
        end
        if (expQ.size() > 0) lastW = expQ[expQ.size()-1];
    endtask

    task automatic runFrame(input vec_t v);
        bit ok;
        int nExp;
        int ready;
        bit hdrOk;
        buildFrame(v);
        nExp  = expQ.size();
        hdrOk = (v.n != 16'd0 && int'(v.n) <= CAP);
        writesSeen = 0;
        pulseStart();
        check("busy after start", 32'(busy), 32'd1);
        check("done cleared by start", 32'(done), 32'd0);
        frameCycles = 0;
        foreach (frameQ[i]) begin
            sendByte(frameQ[i], v.randValid, ok);
            if (!ok) begin
                checks++;
                fails++;
                $display("FAIL byte accept timeout: got no accept of byte %0d, required accept", i);
                break;
            end
        end
        check("done", 32'(done), 32'(v.expDone));
        check("err", 32'(err), 32'(v.expErr));
        check("cpu_hold", 32'(cpu_hold), 32'(!v.expDone));
        check("busy at end", 32'(busy), 32'd0);
        check("write count", 32'(writesSeen), 32'(v.expWrites));
        check("writes outstanding", 32'(expQ.size()), 32'd0);
        if (!v.randValid)
            check("frame cycles", 32'(frameCycles), hdrOk ? 32'(3 + 5 * int'(v.n)) : 32'd2);
        if (nExp > 0) begin
            check("im_addr hold", 32'(im_addr), 32'(lastW.addr));
            check("im_wdata hold", im_wdata, lastW.data);
        end
        // A finished loader must not consume further bytes.
        ready = 0;
        rx_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            if (rx_ready) ready++;
            @(posedge CLK);
            #1;
        end
        rx_valid = 1'b0;
        check("rx_ready after frame", 32'(ready), 32'd0);
    endtask

    initial begin
        bit ok;
        int ready;

        //               n        spec flip rand done err writes
        vecs[0] = '{16'h0002, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2};
        vecs[1] = '{16'h0002, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2};
        vecs[2] = '{16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[3] = '{16'h0401, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 0};
        vecs[4] = '{16'h0400, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1024};
        vecs[5] = '{16'h0002, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2};
        vecs[6] = '{16'h0007, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7};
        vecs[7] = '{16'h0001, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1};
        vecs[8] = '{16'h0003, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 3};

        RST      = 1'b0;
        start    = 1'b0;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        #12;
        check("reset cpu_hold", 32'(cpu_hold), 32'd1);
        check("reset rx_ready", 32'(rx_ready), 32'd0);
        check("reset im_we", 32'(im_we), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset done", 32'(done), 32'd0);
        check("reset err", 32'(err), 32'd0);
        check("reset im_addr", 32'(im_addr), 32'd0);
        check("reset im_wdata", im_wdata, 32'd0);
        @(posedge CLK);
        #1;
        RST = 1'b1;

        // Idle loader ignores a valid stream without a start.
        ready = 0;
        rx_valid = 1'b1;
        rx_data  = 8'hA5;
        for (int c = 0; c < 20; c++) begin
            if (rx_ready) ready++;
            @(posedge CLK);
            #1;
        end
        rx_valid = 1'b0;
        check("idle bytes taken", 32'(ready), 32'd0);
        check("idle cpu_hold", 32'(cpu_hold), 32'd1);

        for (int i = 0; i < 9; i++) runFrame(vecs[i]);

        // Reset in the middle of the payload, then a clean reload.
        buildFrame(vecs[0]);
        expQ.delete();
        pulseStart();
        for (int i = 0; i < 6; i++) begin
            sendByte(frameQ[i], 1'b0, ok);
            if (!ok) begin
                checks++;
                fails++;
                $display("FAIL mid-frame accept timeout: got no accept of byte %0d, required accept", i);
                break;
            end
        end
        RST = 1'b0;
        #1;
        check("async reset rx_ready", 32'(rx_ready), 32'd0);
        check("async reset im_we", 32'(im_we), 32'd0);
        check("async reset im_addr", 32'(im_addr), 32'd0);
        check("async reset im_wdata", im_wdata, 32'd0);
        check("async reset busy", 32'(busy), 32'd0);
        check("async reset cpu_hold", 32'(cpu_hold), 32'd1);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        runFrame(vecs[0]);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
